// File: rtl/sm3_msg_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : sm3_msg_feeder
//  Purpose  : Host-side initiator for an SM3 compression core. Collects a
//             big-endian 32-bit word stream into 512-bit blocks, applies SM3
//             padding (0x80 marker, zero fill, 64-bit big-endian bit length),
//             launches the core once per block, chains each result into the
//             next block and presents the final 256-bit digest.
//  Options  : SM3_LEN_ERR_EN - adds the sticky len_err_o output that flags a
//             message whose bit length exceeded 2^LEN_W-1 (the length is
//             still wrapped into the digest).
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             msg_data_i       - message word, byte 0 in [31:24]
//             msg_valid_i      - word present
//             msg_ready_o      - word accepted this cycle when valid
//             msg_last_i       - final word of the message
//             msg_bytes_i      - valid bytes (0..4) in the final word
//             core_start_o     - one-cycle start pulse to the core
//             core_data_o      - 512-bit block, word 0 in [511:480]
//             core_cv_o        - chaining value {A..H}
//             core_hash_i      - core result (already XORed with cv)
//             core_valid_i     - one-cycle result strobe
//             hash_out_o       - final digest, held until the next one
//             hash_valid_o     - one-cycle digest strobe
//             busy_o           - a message or block is in progress
//             len_err_o        - (SM3_LEN_ERR_EN only) length overflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module sm3_msg_feeder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  msg_data_i,
  input  logic         msg_valid_i,
  output logic         msg_ready_o,
  input  logic         msg_last_i,
  input  logic [2:0]   msg_bytes_i,
  output logic         core_start_o,
  output logic [511:0] core_data_o,
  output logic [255:0] core_cv_o,
  input  logic [255:0] core_hash_i,
  input  logic         core_valid_i,
  output logic [255:0] hash_out_o,
  output logic         hash_valid_o,
  output logic         busy_o
`ifdef SM3_LEN_ERR_EN
  ,
  output logic         len_err_o
`endif
);

  localparam logic [255:0] c_iv = {
    32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
    32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e
  };

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_PAD  = 2'd1,
    S_HASH = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            state_q,  state_d;
  state_t            resume_q, resume_d;   // where to continue after a block
  logic [31:0]       blk_q [16];
  logic [31:0]       blk_d [16];
  logic [4:0]        wcnt_q,   wcnt_d;     // 0..16, 16 means block full
  logic [LEN_W-1:0]  bitlen_q, bitlen_d;
  logic              marker_q, marker_d;   // 0x80 marker already placed
  logic              lenhi_q,  lenhi_d;    // upper length word placed
  logic              final_q,  final_d;    // current block carries the length
  logic              started_q, started_d; // a message has begun
  logic [255:0]      cv_q,     cv_d;
  logic [255:0]      hash_q,   hash_d;
  logic              hvalid_q, hvalid_d;
`ifdef SM3_LEN_ERR_EN
  logic              len_err_q, len_err_d;
  logic              w_len_ovf;
  localparam logic [64:0] c_len_max = (65'd1 << LEN_W) - 65'd1;
`endif

  // --------------------------------------------------------------------------
  // Word-level helpers
  // --------------------------------------------------------------------------
  logic              w_accept;
  logic [2:0]        w_nbytes;     // msg_bytes_i clamped to 4
  logic [31:0]       w_last_word;  // final word with tail bytes replaced
  logic [5:0]        w_inc;        // bits added by the accepted word
  logic [63:0]       w_len64;

  assign msg_ready_o = (state_q == S_LOAD) && !rst;
  assign w_accept    = msg_valid_i && msg_ready_o;
  assign w_nbytes    = (msg_bytes_i > 3'd4) ? 3'd4 : msg_bytes_i;
  assign w_inc       = msg_last_i ? {w_nbytes, 3'b000} : 6'd32;
  assign w_len64     = 64'(bitlen_q);

  // Bytes at or beyond the valid count are cleared; the first of them gets
  // the padding marker so a partial final word needs no extra pad cycle.
  always_comb begin
    w_last_word = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < w_nbytes) begin
        w_last_word[31-8*k -: 8] = msg_data_i[31-8*k -: 8];
      end else if (3'(k) == w_nbytes) begin
        w_last_word[31-8*k -: 8] = 8'h80;
      end
    end
  end

`ifdef SM3_LEN_ERR_EN
  assign w_len_ovf = (65'(bitlen_q) + 65'(w_inc)) > c_len_max;
`endif

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    resume_d  = resume_q;
    blk_d     = blk_q;
    wcnt_d    = wcnt_q;
    bitlen_d  = bitlen_q;
    marker_d  = marker_q;
    lenhi_d   = lenhi_q;
    final_d   = final_q;
    started_d = started_q;
    cv_d      = cv_q;
    hash_d    = hash_q;
    hvalid_d  = 1'b0;
`ifdef SM3_LEN_ERR_EN
    len_err_d = len_err_q;
`endif

    case (state_q)
      S_LOAD: begin
        if (w_accept) begin
          started_d = 1'b1;
          wcnt_d    = wcnt_q + 5'd1;
          bitlen_d  = bitlen_q + LEN_W'(w_inc);
`ifdef SM3_LEN_ERR_EN
          if (!started_q) begin
            len_err_d = 1'b0;
          end
          if (w_len_ovf) begin
            len_err_d = 1'b1;
          end
`endif
          if (msg_last_i) begin
            blk_d[wcnt_q[3:0]] = w_last_word;
            marker_d           = (w_nbytes != 3'd4);
            if (wcnt_q == 5'd15) begin
              state_d  = S_HASH;
              resume_d = S_PAD;
              final_d  = 1'b0;
            end else begin
              state_d  = S_PAD;
            end
          end else begin
            blk_d[wcnt_q[3:0]] = msg_data_i;
            if (wcnt_q == 5'd15) begin
              state_d  = S_HASH;
              resume_d = S_LOAD;
              final_d  = 1'b0;
            end
          end
        end
      end

      S_PAD: begin
        wcnt_d = wcnt_q + 5'd1;
        // The marker always precedes the length; the length only ever lands
        // in words 14/15, so a late marker pushes it into an extra block.
        if (!marker_q) begin
          blk_d[wcnt_q[3:0]] = 32'h8000_0000;
          marker_d           = 1'b1;
        end else if (wcnt_q == 5'd14) begin
          blk_d[wcnt_q[3:0]] = w_len64[63:32];
          lenhi_d            = 1'b1;
        end else if ((wcnt_q == 5'd15) && lenhi_q) begin
          blk_d[wcnt_q[3:0]] = w_len64[31:0];
          final_d            = 1'b1;
        end else begin
          blk_d[wcnt_q[3:0]] = 32'h0000_0000;
        end
        if (wcnt_q == 5'd15) begin
          state_d  = S_HASH;
          resume_d = S_PAD;
        end
      end

      S_HASH: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (core_valid_i) begin
          cv_d   = core_hash_i;
          wcnt_d = 5'd0;
          if (final_q) begin
            hash_d    = core_hash_i;
            hvalid_d  = 1'b1;
            cv_d      = c_iv;
            bitlen_d  = '0;
            marker_d  = 1'b0;
            lenhi_d   = 1'b0;
            final_d   = 1'b0;
            started_d = 1'b0;
            state_d   = S_LOAD;
          end else begin
            state_d   = resume_q;
          end
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOAD;
      resume_q  <= S_LOAD;
      for (int i = 0; i < 16; i++) begin
        blk_q[i] <= 32'h0000_0000;
      end
      wcnt_q    <= 5'd0;
      bitlen_q  <= '0;
      marker_q  <= 1'b0;
      lenhi_q   <= 1'b0;
      final_q   <= 1'b0;
      started_q <= 1'b0;
      cv_q      <= c_iv;
      hash_q    <= '0;
      hvalid_q  <= 1'b0;
`ifdef SM3_LEN_ERR_EN
      len_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      resume_q  <= resume_d;
      blk_q     <= blk_d;
      wcnt_q    <= wcnt_d;
      bitlen_q  <= bitlen_d;
      marker_q  <= marker_d;
      lenhi_q   <= lenhi_d;
      final_q   <= final_d;
      started_q <= started_d;
      cv_q      <= cv_d;
      hash_q    <= hash_d;
      hvalid_q  <= hvalid_d;
`ifdef SM3_LEN_ERR_EN
      len_err_q <= len_err_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 16; gi++) begin : g_flat
    assign core_data_o[511-32*gi -: 32] = blk_q[gi];
  end

  assign core_start_o = (state_q == S_HASH);
  assign core_cv_o    = cv_q;
  assign hash_out_o   = hash_q;
  assign hash_valid_o = hvalid_q;
  // Idle only when parked in S_LOAD on an empty block with no message open;
  // S_LOAD between blocks of a long message still counts as busy.
  assign busy_o       = !((state_q == S_LOAD) && (wcnt_q == 5'd0) && !started_q);
`ifdef SM3_LEN_ERR_EN
  assign len_err_o    = len_err_q;
`endif

endmodule
`default_nettype wire
